// File: rtl/gf256_pkg.sv
// Shared GF(2^8) types and constants for the Reed-Solomon datapath blocks.
package gf256_pkg;

    localparam logic [8:0] GF_POLY   = 9'h11D;
    localparam int         EXP_STEPS = 7;

    typedef logic [7:0] gf_elem_t;

    typedef enum logic [1:0] {
        IDLE,
        EXP,
        FINAL,
        DONE
    } state_t;

endpackage

// File: rtl/gf256_mul_comb.sv
// Combinational GF(2^8) multiply: carry-less 8x8 product reduced modulo POLY.
module gf256_mul_comb
    import gf256_pkg::*;
#(
    parameter logic [8:0] POLY = GF_POLY
) (
    input  gf_elem_t a,
    input  gf_elem_t b,
    output gf_elem_t p
);

    logic [14:0] prod;

    always_comb begin
        prod = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                prod = prod ^ (15'(a) << i);
            end
        end
        // Fold the high terms down from the top so each step clears bit i.
        for (int i = 14; i >= 8; i--) begin
            if (prod[i]) begin
                prod = prod ^ (15'(POLY) << (i - 8));
            end
        end
        p = prod[7:0];
    end

endmodule

// File: rtl/gf256_div_seq.sv
// Sequential GF(2^8) divider q = a * b^254; fixed 8-clock latency from accept to out_valid.
// One operation in flight; result held in DONE until out_ready, then IDLE the following cycle.
module gf256_div_seq
    import gf256_pkg::*;
#(
    parameter logic [8:0] POLY = GF_POLY
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_q,
    output logic       out_div_by_zero,
    output logic       busy
);

    state_t     state;
    gf_elem_t   a_r;
    gf_elem_t   x;
    gf_elem_t   acc;
    gf_elem_t   x_sq;
    gf_elem_t   m1_a;
    gf_elem_t   m1_b;
    gf_elem_t   m1_p;
    logic [2:0] step;
    logic       zflag;

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // Second multiplier accumulates acc*x^2 during EXP and forms a*b^-1 in FINAL.
    assign m1_a = (state == FINAL) ? a_r : acc;
    assign m1_b = (state == FINAL) ? acc : x_sq;

    gf256_mul_comb #(.POLY(POLY)) u_sq (
        .a (x),
        .b (x),
        .p (x_sq)
    );

    gf256_mul_comb #(.POLY(POLY)) u_mul (
        .a (m1_a),
        .b (m1_b),
        .p (m1_p)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            out_valid       <= 1'b0;
            out_q           <= 8'h00;
            out_div_by_zero <= 1'b0;
            a_r             <= 8'h00;
            x               <= 8'h00;
            acc             <= 8'h00;
            step            <= 3'd0;
            zflag           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= in_a;
                        x     <= in_b;
                        acc   <= 8'h01;
                        step  <= 3'd0;
                        zflag <= (in_b == 8'h00);
                        state <= EXP;
                    end
                end
                EXP: begin
                    // After k steps acc = b^(2+4+..+2^k); seven steps give b^254.
                    x    <= x_sq;
                    acc  <= m1_p;
                    step <= step + 3'd1;
                    if (step == 3'(EXP_STEPS - 1)) begin
                        state <= FINAL;
                    end
                end
                FINAL: begin
                    out_q           <= zflag ? 8'h00 : m1_p;
                    out_div_by_zero <= zflag;
                    out_valid       <= 1'b1;
                    state           <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gf256_div_seq.sv
// Directed-vector bench for gf256_div_seq with latency, backpressure, reset-abort and sweep checks.
module tb_gf256_div_seq;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_q;
    logic       out_div_by_zero;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic       dbz;
    } vec_t;

    vec_t vecs[11];

    gf256_div_seq dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_a            (in_a),
        .in_b            (in_b),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_q           (out_q),
        .out_div_by_zero (out_div_by_zero),
        .busy            (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] r;
        logic [7:0] t;
        r = 8'h00;
        t = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) r = r ^ t;
            t = t[7] ? ((t << 1) ^ 8'h1D) : (t << 1);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [7:0] a, input logic [7:0] b);
        int w;
        w = 0;
        while (!in_ready && w < 30) begin
            tick();
            w++;
        end
        if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_a     = ~a;
        in_b     = ~b;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 30) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat;
        logic seen;
        logic [7:0] av;

        vecs[0]  = '{8'h01, 8'h02, 8'h8E, 1'b0};
        vecs[1]  = '{8'h04, 8'h02, 8'h02, 1'b0};
        vecs[2]  = '{8'h03, 8'h03, 8'h01, 1'b0};
        vecs[3]  = '{8'h00, 8'h05, 8'h00, 1'b0};
        vecs[4]  = '{8'h37, 8'h00, 8'h00, 1'b1};
        vecs[5]  = '{8'h01, 8'h01, 8'h01, 1'b0};
        vecs[6]  = '{8'h02, 8'h01, 8'h02, 1'b0};
        vecs[7]  = '{8'hFF, 8'hFF, 8'h01, 1'b0};
        vecs[8]  = '{8'h01, 8'h8E, 8'h02, 1'b0};
        vecs[9]  = '{8'h8E, 8'h02, 8'h47, 1'b0};
        vecs[10] = '{8'h00, 8'h00, 8'h00, 1'b1};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_a      = 8'h00;
        in_b      = 8'h00;
        out_ready = 1'b1;
        repeat (3) tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_q", 32'(out_q), 32'h00);
        check("rst_dbz", 32'(out_div_by_zero), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        tick();

        foreach (vecs[i]) begin
            start_op(vecs[i].a, vecs[i].b);
            check("busy_after_accept", 32'(busy), 32'd1);
            wait_valid(lat);
            check($sformatf("latency[%0d]", i), 32'(lat), 32'd8);
            check($sformatf("q[%0d]", i), 32'(out_q), 32'(vecs[i].q));
            check($sformatf("dbz[%0d]", i), 32'(out_div_by_zero), 32'(vecs[i].dbz));
            check($sformatf("in_ready_while_valid[%0d]", i), 32'(in_ready), 32'd0);
            tick();
            check($sformatf("drained[%0d]", i), 32'(out_valid), 32'd0);
            check($sformatf("in_ready_after_drain[%0d]", i), 32'(in_ready), 32'd1);
        end

        // Backpressure: hold the result 20 cycles while poking in_valid.
        out_ready = 1'b0;
        start_op(8'h04, 8'h02);
        wait_valid(lat);
        check("bp_latency", 32'(lat), 32'd8);
        for (int c = 0; c < 20; c++) begin
            in_valid = c[0];
            in_a     = 8'(c);
            in_b     = 8'(c + 1);
            tick();
            check("bp_q_stable", 32'(out_q), 32'h02);
            check("bp_valid_held", 32'(out_valid), 32'd1);
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_drained", 32'(out_valid), 32'd0);
        check("bp_idle", 32'(in_ready), 32'd1);
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (out_valid || busy) seen = 1'b1;
        end
        check("bp_no_ghost_op", 32'(seen), 32'd0);

        // Reset in the middle of EXP aborts the operation.
        start_op(8'h03, 8'h07);
        repeat (3) tick();
        check("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        seen  = 1'b0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_result", 32'(seen), 32'd0);
        start_op(8'h01, 8'h02);
        wait_valid(lat);
        check("post_abort_latency", 32'(lat), 32'd8);
        check("post_abort_q", 32'(out_q), 32'h8E);
        tick();

        // Back-to-back sweep over every nonzero divisor with several dividends.
        for (int b = 1; b < 256; b++) begin
            for (int k = 0; k < 4; k++) begin
                case (k)
                    0: av = 8'(b);
                    1: av = 8'(b) ^ 8'h5A;
                    2: av = 8'h01;
                    default: av = 8'($urandom_range(0, 255));
                endcase
                start_op(av, 8'(b));
                wait_valid(lat);
                check($sformatf("sweep a=%0h b=%0h", av, b),
                      {22'd0, 1'(lat != 8), out_div_by_zero, gf_mul(out_q, 8'(b))},
                      {24'd0, av});
                tick();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
